// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: cache-side and RAM-side signals of the shared memory port
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic [DATA_W-1:0] iload;
  logic              iwait;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic [DATA_W-1:0] dload;
  logic              dwait;
  logic              ram_req;
  logic              ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_store;
  logic [DATA_W-1:0] ram_load;
  logic              ram_ack;
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ram_load, ram_ack,
    output iload, iwait, dload, dwait, ram_req, ram_wen, ram_addr, ram_store
  );
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ram_load, ram_ack,
    input  iload, iwait, dload, dwait, ram_req, ram_wen, ram_addr, ram_store
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between icache and dcache; ARB_RR_EN selects round robin over fixed dcache priority
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic          CLK,
  input logic          RST,
  mem_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_I = 2'd1;
  localparam logic [1:0] GNT_D = 2'd2;
  logic [1:0] state_q, state_d;
  logic d_req, i_act, d_act, i_done, d_done, pick_d;
  assign d_req  = bus.dREN | bus.dWEN;
  // a grant only drives RAM while its owner still requests and reset is low
  assign i_act  = !RST && state_q == GNT_I && bus.iREN;
  assign d_act  = !RST && state_q == GNT_D && d_req;
  assign i_done = i_act & bus.ram_ack;
  assign d_done = d_act & bus.ram_ack;
`ifdef ARB_RR_EN
  logic last_d_q, last_d_d;
  always_comb last_d_d = d_done ? 1'b1 : i_done ? 1'b0 : last_d_q;
  always_ff @(posedge CLK)
    if (RST) last_d_q <= 1'b0;
    else     last_d_q <= last_d_d;
  assign pick_d = d_req & (!bus.iREN | !last_d_q);
`else
  assign pick_d = d_req;
`endif
  always_comb begin
    state_d = state_q == IDLE ? (pick_d ? GNT_D : bus.iREN ? GNT_I : IDLE)
            : ((i_act | d_act) & !bus.ram_ack) ? state_q : IDLE;
  end
  always_ff @(posedge CLK)
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  always_comb begin
    bus.ram_req   = i_act | d_act;
    bus.ram_wen   = d_act & bus.dWEN;
    bus.ram_addr  = d_act ? bus.daddr : i_act ? bus.iaddr : {ADDR_W{1'b0}};
    bus.ram_store = d_act ? bus.dstore : {DATA_W{1'b0}};
    bus.iwait     = !i_done;
    bus.dwait     = !d_done;
    bus.iload     = bus.ram_load;
    bus.dload     = bus.ram_load;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  int n_cmp = 0;
  int n_err = 0;
  int owner = 0;
  bit last_d = 1'b0;
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (.CLK(clk), .RST(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic half();
    bit dreq, act, req;
    @(negedge clk);
    dreq = bus.dREN | bus.dWEN;
    act  = owner == 2 ? dreq : owner == 1 ? bus.iREN : 1'b0;
    req  = !rst && act;
    chk("m_req", {31'd0, bus.ram_req}, {31'd0, req});
    chk("m_iwait", {31'd0, bus.iwait}, {31'd0, !(req && owner == 1 && bus.ram_ack)});
    chk("m_dwait", {31'd0, bus.dwait}, {31'd0, !(req && owner == 2 && bus.ram_ack)});
    chk("m_iload", bus.iload, bus.ram_load);
    chk("m_dload", bus.dload, bus.ram_load);
    if (rst) begin
      chk("m_rst_addr", bus.ram_addr, 32'd0);
      chk("m_rst_wen", {31'd0, bus.ram_wen}, 32'd0);
      chk("m_rst_store", bus.ram_store, 32'd0);
    end else if (req) begin
      chk("m_addr", bus.ram_addr, owner == 2 ? bus.daddr : bus.iaddr);
      chk("m_wen", {31'd0, bus.ram_wen}, {31'd0, owner == 2 && bus.dWEN});
      if (owner == 2) chk("m_store", bus.ram_store, bus.dstore);
    end
  endtask

  task automatic adv();
    bit dreq, act, prefer_d;
    @(posedge clk);
    dreq = bus.dREN | bus.dWEN;
`ifdef ARB_RR_EN
    prefer_d = !last_d;
`else
    prefer_d = 1'b1;
`endif
    if (rst) begin
      owner = 0;
      last_d = 1'b0;
    end else if (owner == 0) begin
      if (dreq && (!bus.iREN || prefer_d)) owner = 2;
      else if (bus.iREN) owner = 1;
    end else begin
      act = owner == 2 ? dreq : bus.iREN;
      if (act && bus.ram_ack) begin
        last_d = owner == 2;
        owner = 0;
      end else if (!act) owner = 0;
    end
    #1;
  endtask

  task automatic cyc();
    half();
    adv();
  endtask

  task automatic quiet();
    bus.iREN = 0; bus.dREN = 0; bus.dWEN = 0; bus.ram_ack = 0;
  endtask

  initial begin
    rst = 1; quiet();
    bus.iaddr = 0; bus.daddr = 0; bus.dstore = 0; bus.ram_load = 32'h5555_AAAA;
    half();
    chk("rst_req", {31'd0, bus.ram_req}, 32'd0);
    chk("rst_waits", {30'd0, bus.iwait, bus.dwait}, 32'd3);
    adv(); cyc();
    rst = 0; cyc();
    // single icache read, ack two cycles after grant
    bus.iREN = 1; bus.iaddr = 32'h40; bus.ram_load = 32'hDEADBEEF;
    half(); chk("ird_c0_req", {31'd0, bus.ram_req}, 32'd0); adv();
    half(); chk("ird_c1_addr", bus.ram_addr, 32'h40); adv();
    half(); chk("ird_c2_iwait", {31'd0, bus.iwait}, 32'd1); adv();
    bus.ram_ack = 1;
    half();
    chk("ird_c3_iwait", {31'd0, bus.iwait}, 32'd0);
    chk("ird_c3_iload", bus.iload, 32'hDEADBEEF);
    chk("ird_c3_dwait", {31'd0, bus.dwait}, 32'd1);
    adv();
    quiet(); cyc();
    // simultaneous requests: dcache write wins, icache after one IDLE
    bus.dWEN = 1; bus.daddr = 32'h80; bus.dstore = 32'h1234; bus.iREN = 1; bus.iaddr = 0;
    cyc();
    bus.ram_ack = 1;
    half();
    chk("sim_d_wen", {31'd0, bus.ram_wen}, 32'd1);
    chk("sim_d_addr", bus.ram_addr, 32'h80);
    chk("sim_d_dwait", {31'd0, bus.dwait}, 32'd0);
    chk("sim_d_iwait", {31'd0, bus.iwait}, 32'd1);
    adv();
    bus.dWEN = 0; bus.ram_ack = 0;
    half(); chk("sim_idle_req", {31'd0, bus.ram_req}, 32'd0); adv();
    bus.ram_ack = 1;
    half();
    chk("sim_i_addr", bus.ram_addr, 32'h0);
    chk("sim_i_iwait", {31'd0, bus.iwait}, 32'd0);
    adv();
    quiet(); cyc();
    // continuous contention with immediate acks
    bus.dREN = 1; bus.daddr = 32'h100; bus.iREN = 1; bus.iaddr = 32'h200; bus.ram_ack = 1;
    for (int k = 0; k < 8; k++) begin
      half();
      if (k % 2 == 0) chk("cont_idle", {31'd0, bus.ram_req}, 32'd0);
`ifdef ARB_RR_EN
      else chk("cont_rr_addr", bus.ram_addr, (k % 4 == 1) ? 32'h100 : 32'h200);
`else
      else chk("cont_fix_addr", bus.ram_addr, 32'h100);
`endif
      adv();
    end
    quiet(); cyc();
    // dREN and dWEN together is a write
    bus.dREN = 1; bus.dWEN = 1; bus.daddr = 32'hC0; bus.dstore = 32'hCAFE_F00D;
    cyc();
    half();
    chk("rw_wen", {31'd0, bus.ram_wen}, 32'd1);
    chk("rw_store", bus.ram_store, 32'hCAFE_F00D);
    adv();
    bus.ram_ack = 1; cyc();
    quiet(); cyc();
    // abandon then late ack
    bus.dREN = 1; bus.daddr = 32'hE0;
    cyc(); cyc();
    bus.dREN = 0;
    half(); chk("ab_req", {31'd0, bus.ram_req}, 32'd0); adv();
    bus.ram_ack = 1;
    half(); chk("ab_late_dwait", {31'd0, bus.dwait}, 32'd1); adv();
    quiet(); cyc();
    // reset during an icache grant
    bus.iREN = 1; bus.iaddr = 32'h44;
    cyc(); cyc();
    rst = 1;
    half();
    chk("rmid_req", {31'd0, bus.ram_req}, 32'd0);
    chk("rmid_iwait", {31'd0, bus.iwait}, 32'd1);
    adv();
    rst = 0; bus.dREN = 1; bus.daddr = 32'h88;
    cyc();
    half(); chk("rmid_d_first", bus.ram_addr, 32'h88); adv();
    quiet(); cyc();
    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 9) < 2) bus.iREN = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 9) < 2) begin
        bus.dREN = $urandom_range(0, 1) != 0;
        bus.dWEN = $urandom_range(0, 2) == 0;
      end
      if ($urandom_range(0, 7) == 0) bus.iaddr = $urandom;
      if ($urandom_range(0, 7) == 0) bus.daddr = $urandom;
      if ($urandom_range(0, 7) == 0) bus.dstore = $urandom;
      bus.ram_load = $urandom;
      bus.ram_ack = $urandom_range(0, 9) < 4;
      cyc();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single shared RAM port between the instruction cache and the data cache. It sits between both caches' memory-side signals and the RAM model. It runs one transaction at a time, locks the grant until RAM acknowledges, and returns per-requester wait signals in the caches_if style: wait stays high until the cycle the access completes.

## Interface
Parameters:
- ADDR_W, 32, address width of all address ports
- DATA_W, 32, data width of all data ports

Ports (reset is synchronous, active-high):
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  synchronous active-high reset
- iREN  in  1  icache read request
- iaddr  in  ADDR_W  icache request address
- iload  out  DATA_W  icache read data; valid when iwait low
- iwait  out  1  icache wait; low for exactly the completing cycle
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  ADDR_W  dcache request address
- dstore  in  DATA_W  dcache write data
- dload  out  DATA_W  dcache read data; valid when dwait low
- dwait  out  1  dcache wait; low for exactly the completing cycle
- ram_req  out  1  RAM access request, held until ram_ack
- ram_wen  out  1  1 = write, 0 = read; qualified by ram_req
- ram_addr  out  ADDR_W  RAM address
- ram_store  out  DATA_W  RAM write data
- ram_load  in  DATA_W  RAM read data; valid when ram_ack high
- ram_ack  in  1  one-cycle completion pulse from RAM

## Operation
- FSM states: IDLE, GNT_I, GNT_D. State is registered. RST forces IDLE. RST also sets last_grant to I, which makes D the first round-robin winner.
- IDLE:
  - No RAM request.
  - If the dcache request (dREN|dWEN) is high and the icache request is not, go to GNT_D.
  - If only iREN is high, go to GNT_I.
  - If both are high, the priority rule decides (see Configuration).
- GNT_D:
  - ram_req=1, ram_addr=daddr, ram_store=dstore, ram_wen=dWEN.
  - If dWEN and dREN are both high, it is a write.
  - On ram_ack: dwait=0, dload=ram_load, then next state is IDLE and last_grant becomes D.
- GNT_I:
  - ram_req=1, ram_wen=0, ram_addr=iaddr.
  - On ram_ack: iwait=0, iload=ram_load, then next state is IDLE and last_grant becomes I.
- Abandon: if the granted requester drops its request before ram_ack, drop ram_req in that same cycle (combinational) and go to IDLE. last_grant is unchanged.
- iwait and dwait are 1 in every cycle except their own completion cycle, whether or not the cache is requesting.
- iload and dload pass ram_load through at all times. They are meaningful only when the matching wait is low.
- ram_ack while in IDLE, or while the RAM request is withdrawn, is ignored and no wait goes low.
- RST high: outputs are forced combinationally to ram_req=0, iwait=1, dwait=1. A RAM transaction in flight is abandoned.

## Timing
- Minimum latency: the request is seen in IDLE at cycle 0, the grant is in place at cycle 1, and the earliest completion (wait low) is cycle 1 if ram_ack returns in the same cycle.
- General latency: completion cycle = grant cycle + RAM latency.
- One mandatory IDLE cycle follows every completion. Back-to-back accesses from one requester therefore take at least 2 cycles each.
- The losing requester sees its wait held high for the full duration of the winner's transaction plus the IDLE cycle.
- ram_addr, ram_wen and ram_store track the granted requester's inputs combinationally. Requesters must hold them stable until their wait goes low.
- Reset value of every output: ram_req=0, ram_wen=0, ram_addr=0, ram_store=0, iwait=1, dwait=1. iload and dload equal ram_load.

## Configuration
- ARB_RR_EN defined: when both caches request in IDLE, the grant goes to the requester that is not last_grant (round robin).
- ARB_RR_EN undefined: the dcache always wins contention. The last_grant register is not generated. icache starvation under continuous dcache traffic is accepted.

## Test plan
- Single icache read:
  - Stimulus: iREN=1, iaddr=0x40, RAM acks 2 cycles after grant with ram_load=0xDEADBEEF.
  - Response: iwait low for one cycle at cycle 3, iload=0xDEADBEEF, dwait stays 1.
- Simultaneous request, fixed priority:
  - Stimulus: dWEN=1, daddr=0x80, dstore=0x1234 together with iREN=1, iaddr=0x0.
  - Response: the RAM sees a write to 0x80 first. The icache is granted only after the dcache completes and one IDLE cycle passes.
- Round robin (ARB_RR_EN defined):
  - Stimulus: dcache and icache both request continuously.
  - Response: grants alternate D, I, D, I starting with D after reset. Each completion is followed by one IDLE cycle.
- dREN and dWEN both high:
  - Response: ram_wen=1 and ram_store=dstore.
- Abandon:
  - Stimulus: the dcache drops dREN mid-wait, then a ram_ack arrives in the following cycle.
  - Response: ram_req=0 in the same cycle the request drops, state returns to IDLE, and the late ack produces no wait-low pulse.
- Reset mid-transaction:
  - Stimulus: RST=1 while in GNT_I.
  - Response: ram_req=0 and iwait=1 immediately. After release, the next simultaneous request grants D first.
